pio_event_sequencer: RTL and testbench
======================================

PIO_EVENT_SEQUENCER -- requirements
Module: pio_event_sequencer

Interface
REQ-001 SHALL have parameter HOLDOFF, default 1000, meaning cycles in HOLD before re-arm (0 = skip HOLD).
REQ-002 SHALL have parameter CNT_W, default 16, meaning evt_count width.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  sequencer run request.
REQ-006 SHALL have port pio_address  out  2  PIO register offset.
REQ-007 SHALL have port pio_chipselect  out  1  PIO select.
REQ-008 SHALL have port pio_write_n  out  1  PIO write strobe, active-low.
REQ-009 SHALL have port pio_writedata  out  32  PIO write data.
REQ-010 SHALL have port pio_readdata  in  32  PIO read data; registered in the PIO, valid one cycle after the address is driven.
REQ-011 SHALL have port pio_irq  in  1  PIO interrupt (edge_capture & mask).
REQ-012 SHALL have port evt_valid  out  1  event available.
REQ-013 SHALL have port evt_ready  in  1  event consumed.
REQ-014 SHALL have port evt_level  out  1  pin level sampled during service.
REQ-015 SHALL have port evt_count  out  CNT_W  serviced-edge count, wraps.
REQ-016 SHALL have port overflow  out  1  sticky; event dropped.
REQ-017 SHALL have port ovf_clr  in  1  clears overflow.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE and WAIT_IRQ.

Function
REQ-019 SHALL implement states IDLE, ARM, WAIT_IRQ, DISARM, RD_CAP, CAP_LAT, CLR, RD_DAT, DAT_LAT, POST, HOLD, STOP.
REQ-020 SHALL drive an idle bus in every state without an access: chipselect 0, write_n 1, address 0, writedata 0.
REQ-021 SHALL go IDLE->ARM when enable=1; ARM issues a one-cycle write of offset 2 with data 1, then goes to WAIT_IRQ.
REQ-022 SHALL go WAIT_IRQ->DISARM when pio_irq=1; DISARM writes offset 2 with data 0; WAIT_IRQ with enable=0 goes to STOP.
REQ-023 SHALL drive a read of offset 3 in RD_CAP (chipselect 1, write_n 1) and sample pio_readdata[0] in CAP_LAT.
REQ-024 SHALL, when the captured bit is 0 (spurious irq), go CAP_LAT->ARM without posting or counting.
REQ-025 SHALL, when the captured bit is 1, go to CLR, which writes offset 3 with data 0, then read offset 0 in RD_DAT and sample bit 0 in DAT_LAT.
REQ-026 SHALL, in POST, increment evt_count modulo 2^CNT_W.
REQ-027 SHALL, in POST with evt_valid=0, load evt_level and set evt_valid the next cycle.
REQ-028 SHALL, in POST with evt_valid=1 and evt_ready=0, drop the event and set overflow; evt_level is unchanged.
REQ-029 SHALL treat POST with evt_valid=1 and evt_ready=1 as consume-then-load: evt_valid stays 1, evt_level takes the new value, no overflow.
REQ-030 SHALL clear evt_valid on evt_valid & evt_ready; evt_level SHALL be stable while evt_valid=1.
REQ-031 SHALL go POST->HOLD (HOLDOFF>0) or POST->ARM (HOLDOFF=0); HOLD counts HOLDOFF cycles then goes to ARM.
REQ-032 SHALL let HOLD exit to STOP when enable=0; between DISARM and POST, enable SHALL be ignored and service SHALL complete.
REQ-033 SHALL have STOP write offset 2 with data 0, then go to IDLE.
REQ-034 SHALL give latency of pio_irq sampled high in WAIT_IRQ at cycle n -> evt_valid=1 at cycle n+8.
REQ-035 SHALL clear overflow on ovf_clr; ovf_clr and a new drop in the same cycle SHALL leave overflow=1.

Reset
REQ-036 SHALL asynchronously force, on reset_n=0: state IDLE, idle bus, evt_valid 0, evt_level 0, evt_count 0, overflow 0, busy 0, holdoff counter 0.
REQ-037 SHALL abandon an in-flight access on reset mid-operation; no completion cycle is issued after release.

Structure
REQ-038 SHALL place the state enum and the PIO offsets (DATA=0, MASK=2, EDGE=3) in shared package pio_seq_pkg.
REQ-039 SHALL be a single module with no sub-module; the holdoff counter is inline.

Verification
REQ-040 SHALL cover: enable=1 from reset -> write offset 2 data 1 within 2 cycles -> state WAIT_IRQ.
REQ-041 SHALL cover: pin rise, PIO model with HOLDOFF=4 -> mask 0, rd 3, wr 3=0, rd 0 in order; evt_valid at n+8, evt_level=1, evt_count=1; ARM 4 cycles after POST.
REQ-042 SHALL cover: pio_irq forced 1 with edge_capture 0 -> no clear write, evt_count unchanged, returns to ARM.
REQ-043 SHALL cover: two edges with evt_ready=0 -> evt_count=2, overflow=1, evt_level from the first edge; ovf_clr -> overflow=0.
REQ-044 SHALL cover: enable=0 during CLR -> service completes, evt_valid=1, then STOP writes mask 0, then IDLE.
REQ-045 SHALL cover: reset_n pulsed low in RD_DAT -> all outputs at reset values in the same cycle, bus idle.

Source files
------------

// File: rtl/pio_seq_pkg.sv
// Shared types and constants for the PIO event sequencer: FSM state encoding
// and the register offsets of the PIO peripheral it drives.
package pio_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_IRQ,
    S_DISARM,
    S_RD_CAP,
    S_CAP_LAT,
    S_CLR,
    S_RD_DAT,
    S_DAT_LAT,
    S_POST,
    S_HOLD,
    S_STOP
  } seq_state_e;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd2;
  localparam logic [1:0] OFF_EDGE = 2'd3;

endpackage

// File: rtl/pio_event_sequencer_if.sv
// Bundle of the PIO register bus and the event output stream of the sequencer.
// evt stream: an event transfers on every clock edge where evt_valid & evt_ready;
// evt_valid never drops and evt_level never changes until that transfer happens.
interface pio_event_sequencer_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_level;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_level,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_level,
    output evt_ready
  );
endinterface

// File: rtl/pio_event_sequencer.sv
// Services PIO edge interrupts: disarm, confirm the edge capture, clear it, read
// the pin level, post it as an event, optionally hold off, then re-arm.
module pio_event_sequencer
  import pio_seq_pkg::*;
#(
  parameter int HOLDOFF = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_level,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy,
  output seq_state_e       state_dbg
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  seq_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt;
  logic          dat_q;
  logic          drop;

  assign state_dbg = state_q;
  assign busy      = !(state_q inside {S_IDLE, S_WAIT_IRQ});
  assign drop      = (state_q == S_POST) && evt_valid && !evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Bus outputs decode straight from the state so reset idles the bus at once.
  always_comb begin
    state_d        = state_q;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 2'd0;
    pio_writedata  = 32'd0;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_ARM;
      S_ARM: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = OFF_MASK;
        pio_writedata  = 32'd1;
        state_d        = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (pio_irq)      state_d = S_DISARM;
        else if (!enable) state_d = S_STOP;
      end
      S_DISARM: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = OFF_MASK;
        state_d        = S_RD_CAP;
      end
      S_RD_CAP: begin
        pio_chipselect = 1'b1;
        pio_address    = OFF_EDGE;
        state_d        = S_CAP_LAT;
      end
      S_CAP_LAT:  state_d = pio_readdata[0] ? S_CLR : S_ARM;
      S_CLR: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = OFF_EDGE;
        state_d        = S_RD_DAT;
      end
      S_RD_DAT: begin
        pio_chipselect = 1'b1;
        pio_address    = OFF_DATA;
        state_d        = S_DAT_LAT;
      end
      S_DAT_LAT:  state_d = S_POST;
      S_POST:     state_d = (HOLDOFF > 0) ? S_HOLD : S_ARM;
      S_HOLD: begin
        if (!enable)            state_d = S_STOP;
        else if (hold_cnt == '0) state_d = S_ARM;
      end
      S_STOP: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_address    = OFF_MASK;
        state_d        = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      dat_q    <= 1'b0;
    end else begin
      if (state_q == S_DAT_LAT) dat_q <= pio_readdata[0];
      if (state_q == S_POST)
        hold_cnt <= HOLD_LOAD;
      else if (state_q == S_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // A pending event consumed in the POST cycle is replaced rather than dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_level <= 1'b0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= drop | (overflow & ~ovf_clr);
      if (state_q == S_POST) begin
        evt_count <= evt_count + 1'b1;
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_level <= dat_q;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Bench for pio_event_sequencer: a register-level PIO model, randomized pin
// edges and consumer stalls, and scoreboards for bus accesses and events.
module tb_pio_event_sequencer;
  import pio_seq_pkg::*;

  localparam int HOLDOFF = 4;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             enable;
  logic             ovf_clr;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             busy;
  seq_state_e       dut_state;

  pio_event_sequencer_if bus();

  pio_event_sequencer #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(bus.pio_address), .pio_chipselect(bus.pio_chipselect),
    .pio_write_n(bus.pio_write_n), .pio_writedata(bus.pio_writedata),
    .pio_readdata(bus.pio_readdata), .pio_irq(bus.pio_irq),
    .evt_valid(bus.evt_valid), .evt_ready(bus.evt_ready), .evt_level(bus.evt_level),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .busy(busy), .state_dbg(dut_state)
  );

  // ---------------- PIO peripheral model ----------------
  logic pin, pin_d, mask_r, edge_r, irq_force;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_d <= 1'b0; mask_r <= 1'b0; edge_r <= 1'b0; bus.pio_readdata <= 32'd0;
    end else begin
      pin_d <= pin;
      if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == OFF_EDGE)
        edge_r <= pin & ~pin_d;
      else
        edge_r <= edge_r | (pin & ~pin_d);
      if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == OFF_MASK)
        mask_r <= bus.pio_writedata[0];
      if (bus.pio_chipselect && bus.pio_write_n)
        case (bus.pio_address)
          OFF_DATA: bus.pio_readdata <= {31'd0, pin};
          OFF_MASK: bus.pio_readdata <= {31'd0, mask_r};
          OFF_EDGE: bus.pio_readdata <= {31'd0, edge_r};
          default:  bus.pio_readdata <= 32'd0;
        endcase
    end
  end
  assign bus.pio_irq = (edge_r & mask_r) | irq_force;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [34:0] exp_bus_q[$];   // {is_write, address, writedata}
  logic        exp_evt_q[$];   // expected levels in delivery order
  int exp_count = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  task automatic exp_wr(input logic [1:0] a, input logic [31:0] d);
    exp_bus_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [1:0] a);
    exp_bus_q.push_back({1'b0, a, 32'd0});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int         t_irq = 0;
  int         hold_len = 0;
  logic       prev_valid = 1'b0;
  seq_state_e prev_state = S_IDLE;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0; hold_len = 0; prev_state = S_IDLE;
    end else begin
      if (bus.pio_chipselect) begin
        if (exp_bus_q.size() == 0) begin
          check("bus_unexpected", 64'({~bus.pio_write_n, bus.pio_address}), 64'd0);
        end else begin
          check("bus_access", 64'({~bus.pio_write_n, bus.pio_address,
                                   bus.pio_write_n ? 32'd0 : bus.pio_writedata}),
                64'(exp_bus_q.pop_front()));
        end
      end else begin
        check("bus_idle", 64'({bus.pio_write_n, bus.pio_address, bus.pio_writedata}),
              64'({1'b1, 2'd0, 32'd0}));
      end
      if (bus.evt_valid && bus.evt_ready) begin
        if (exp_evt_q.size() == 0) check("evt_unexpected", 64'(bus.evt_level), 64'd2);
        else check("evt_level", 64'(bus.evt_level), 64'(exp_evt_q.pop_front()));
      end
      if (dut_state == S_WAIT_IRQ && bus.pio_irq) t_irq = cyc;
      if (bus.evt_valid && !prev_valid) check("irq_to_valid_latency", 64'(cyc - t_irq), 64'd8);
      if (dut_state == S_HOLD) hold_len++;
      else begin
        if (prev_state == S_HOLD && dut_state == S_ARM)
          check("hold_cycles", 64'(hold_len), 64'(HOLDOFF));
        hold_len = 0;
      end
      check("busy", 64'(busy), 64'(!(dut_state == S_IDLE || dut_state == S_WAIT_IRQ)));
      prev_valid = bus.evt_valid;
      prev_state = dut_state;
    end
  end

  // ---------------- consumer ----------------
  logic consumer_en;
  logic ready_force;
  initial begin
    int wait_left;
    wait_left = 0;
    bus.evt_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!consumer_en) bus.evt_ready = ready_force;
      else if (bus.evt_ready) begin
        bus.evt_ready = 1'b0;
        wait_left = $urandom_range(0, 4);
      end else if (bus.evt_valid) begin
        if (wait_left == 0) bus.evt_ready = 1'b1;
        else wait_left--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input seq_state_e s, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (dut_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (dut_state != s) begin
      fails++;
      $display("FAIL %s: state %s, required %s", name, dut_state.name(), s.name());
    end
  endtask

  // From WAIT_IRQ: produce a real pin edge and run one full service.
  // post_mode: 0 none, 1 evt_ready pulse in POST, 2 ovf_clr pulse in POST.
  task automatic do_edge(input bit long_pulse, input bit posted, input int post_mode);
    @(posedge clk); #1;
    pin = 1'b1;
    exp_wr(OFF_MASK, 32'd0); exp_rd(OFF_EDGE); exp_wr(OFF_EDGE, 32'd0); exp_rd(OFF_DATA);
    exp_wr(OFF_MASK, 32'd1);
    if (posted) exp_evt_q.push_back(long_pulse);
    exp_count++;
    if (!long_pulse) begin @(posedge clk); #1; pin = 1'b0; end
    wait_state(S_DAT_LAT, 20, "reach_dat_lat");
    pin = 1'b0;
    if (post_mode == 1) begin
      @(posedge clk); #1; ready_force = 1'b1;
      @(posedge clk); #1; ready_force = 1'b0;
    end else if (post_mode == 2) begin
      @(posedge clk); #1; ovf_clr = 1'b1;
      @(posedge clk); #1; ovf_clr = 1'b0;
    end
    wait_state(S_WAIT_IRQ, 20, "rearm_after_service");
    check("evt_count", 64'(evt_count), 64'(exp_count[CNT_W-1:0]));
  endtask

  task automatic do_spurious();
    @(posedge clk); #1;
    irq_force = 1'b1;
    exp_wr(OFF_MASK, 32'd0); exp_rd(OFF_EDGE); exp_wr(OFF_MASK, 32'd1);
    wait_state(S_DISARM, 4, "spurious_disarm");
    irq_force = 1'b0;
    wait_state(S_WAIT_IRQ, 10, "spurious_rearm");
    check("spurious_count", 64'(evt_count), 64'(exp_count[CNT_W-1:0]));
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while ((bus.evt_valid || exp_evt_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_evt_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; enable = 1'b0; ovf_clr = 1'b0; pin = 1'b0; irq_force = 1'b0;
    consumer_en = 1'b0; ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(dut_state), 64'(S_IDLE));
    check("rst_bus", 64'({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata}),
          64'({1'b0, 1'b1, 2'd0, 32'd0}));
    check("rst_evt", 64'({bus.evt_valid, bus.evt_level, overflow, busy}), 64'd0);
    check("rst_count", 64'(evt_count), 64'd0);
    reset_n = 1'b1;

    // Enable from reset: arm write, then WAIT_IRQ within two cycles.
    @(posedge clk); #1;
    enable = 1'b1;
    exp_wr(OFF_MASK, 32'd1);
    wait_state(S_WAIT_IRQ, 2, "enable_to_wait_irq");

    // Directed service with a long pin pulse.
    consumer_en = 1'b1;
    do_edge(1'b1, 1'b1, 0);
    do_spurious();

    // Random mix of real edges, pulse widths and spurious interrupts.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) do_spurious();
      else do_edge(1'($urandom_range(0, 1)), 1'b1, 0);
    end
    check("no_overflow_random", 64'(overflow), 64'd0);

    // Overflow: consumer stalled, second event dropped.
    wait_drained("drain_before_ovf");
    consumer_en = 1'b0;
    do_edge(1'b1, 1'b1, 0);
    do_edge(1'b0, 1'b0, 0);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_level_kept", 64'(bus.evt_level), 64'd1);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Consume-then-load in POST, then drop coinciding with ovf_clr.
    do_edge(1'b0, 1'b1, 1);
    check("ctl_no_ovf", 64'(overflow), 64'd0);
    check("ctl_valid", 64'(bus.evt_valid), 64'd1);
    check("ctl_level", 64'(bus.evt_level), 64'd0);
    do_edge(1'b1, 1'b0, 2);
    check("drop_beats_clr", 64'(overflow), 64'd1);
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    check("ovf_cleared_2", 64'(overflow), 64'd0);
    consumer_en = 1'b1;
    wait_drained("drain_after_ovf");

    // Enable dropped during CLR: service completes, then STOP, then IDLE.
    @(posedge clk); #1;
    pin = 1'b1;
    exp_wr(OFF_MASK, 32'd0); exp_rd(OFF_EDGE); exp_wr(OFF_EDGE, 32'd0); exp_rd(OFF_DATA);
    exp_wr(OFF_MASK, 32'd0);
    exp_evt_q.push_back(1'b1);
    exp_count++;
    wait_state(S_CLR, 10, "reach_clr");
    enable = 1'b0;
    wait_state(S_POST, 6, "service_completes");
    pin = 1'b0;
    @(negedge clk);
    check("stop_evt_valid", 64'(bus.evt_valid), 64'd1);
    check("stop_count", 64'(evt_count), 64'(exp_count[CNT_W-1:0]));
    wait_state(S_IDLE, 6, "stop_to_idle");
    wait_drained("drain_after_stop");

    // Reset pulsed while the data read is on the bus.
    @(posedge clk); #1;
    enable = 1'b1;
    exp_wr(OFF_MASK, 32'd1);
    wait_state(S_WAIT_IRQ, 2, "rearm_before_reset");
    @(posedge clk); #1;
    pin = 1'b1;
    exp_wr(OFF_MASK, 32'd0); exp_rd(OFF_EDGE); exp_wr(OFF_EDGE, 32'd0);
    wait_state(S_CLR, 10, "reach_clr_2");
    @(posedge clk); #1;
    check("in_rd_dat", 64'(dut_state), 64'(S_RD_DAT));
    reset_n = 1'b0;
    enable = 1'b0;
    pin = 1'b0;
    #1;
    check("mid_rst_state", 64'(dut_state), 64'(S_IDLE));
    check("mid_rst_bus", 64'({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata}),
          64'({1'b0, 1'b1, 2'd0, 32'd0}));
    check("mid_rst_evt", 64'({bus.evt_valid, bus.evt_level, overflow, busy}), 64'd0);
    check("mid_rst_count", 64'(evt_count), 64'd0);
    exp_count = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(dut_state), 64'(S_IDLE));
    check("bus_queue_empty", 64'(exp_bus_q.size()), 64'd0);
    check("evt_queue_empty", 64'(exp_evt_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: time %0t, required completion before 200000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
